// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector: takes WIDTH-bit words over
// valid/ready and plays them out one bit per clock, back-to-back when possible.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last, accept, load, advance;

  // The bit that goes out next, and the word left over once it has gone.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last      = (state == SHIFT) && (cnt == LAST);
  assign din_ready = !rst && ((state == IDLE) || last);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!last)       advance   = 1'b1;
        else if (accept) load      = 1'b1;  // seamless reload on the final bit
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded straight from the incoming word so the first bit
  // appears on the cycle right after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      cnt         <= '0;
      x_out       <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else if (load) begin
      shreg       <= drop(din);
      cnt         <= '0;
      x_out       <= head(din);
      x_valid     <= 1'b1;
      frame_start <= 1'b1;
    end else if (advance) begin
      shreg       <= drop(shreg);
      cnt         <= cnt + CW'(1);
      x_out       <= head(shreg);
      x_valid     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= '0;
      x_out       <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three configurations run side by side against a
// word-level model, plus literal checks of the serialized streams.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din0 = '0, din1 = '0;
  logic [4:0] din2 = '0;
  logic [2:0] dv = '0;
  logic [2:0] rdy, xo, xv, fs, bz;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv[0]), .din_ready(rdy[0]),
    .x_out(xo[0]), .x_valid(xv[0]), .frame_start(fs[0]), .busy(bz[0]));
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv[1]), .din_ready(rdy[1]),
    .x_out(xo[1]), .x_valid(xv[1]), .frame_start(fs[1]), .busy(bz[1]));
  serial_bit_feeder #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(dv[2]), .din_ready(rdy[2]),
    .x_out(xo[2]), .x_valid(xv[2]), .frame_start(fs[2]), .busy(bz[2]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Word-level model: the word being sent, which bit of it is on the wire,
  // and how many bits remain after that one.
  int          W   [3] = '{8, 8, 5};
  bit          MSB [3] = '{1'b1, 1'b0, 1'b1};
  bit          IDL [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mword [3];
  int          mpos  [3];
  int          mleft [3] = '{0, 0, 0};
  bit          mact  [3] = '{1'b0, 1'b0, 1'b0};

  logic [31:0] cap [3];
  int          nc  [3];
  int          nf  [3];

  function automatic logic [31:0] dinv(input int k);
    if (k == 0) return {24'd0, din0};
    if (k == 1) return {24'd0, din1};
    return {27'd0, din2};
  endfunction

  task automatic cmp(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, k, $time, a, e);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mact[k]  <= 1'b0;
        mleft[k] <= 0;
      end else if (dv[k] && mleft[k] == 0) begin
        mword[k] <= dinv(k);
        mpos[k]  <= 0;
        mleft[k] <= W[k] - 1;
        mact[k]  <= 1'b1;
      end else if (mleft[k] > 0) begin
        mpos[k]  <= mpos[k] + 1;
        mleft[k] <= mleft[k] - 1;
      end else begin
        mact[k]  <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus stream capture.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (chk_en) begin
        logic ex;
        ex = !mact[k] ? IDL[k] :
             (MSB[k] ? mword[k][W[k]-1-mpos[k]] : mword[k][mpos[k]]);
        cmp("x_out", k, 32'(xo[k]), 32'(ex));
        cmp("x_valid", k, 32'(xv[k]), 32'(mact[k]));
        cmp("frame_start", k, 32'(fs[k]), 32'(mact[k] && mpos[k] == 0));
        cmp("busy", k, 32'(bz[k]), 32'(mact[k]));
        cmp("din_ready", k, 32'(rdy[k]), 32'(!rst && mleft[k] == 0));
      end
      if (xv[k] === 1'b1) begin
        cap[k] = {cap[k][30:0], xo[k]};
        nc[k]++;
        if (fs[k] === 1'b1) nf[k]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      cap[k] = '0;
      nc[k]  = 0;
      nf[k]  = 0;
    end
  endtask

  initial begin
    clr();
    repeat (3) step();
    chk_en = 1'b1;
    cmp("rst_xv0", 0, 32'(xv[0]), 32'd0);
    cmp("rst_xo2", 2, 32'(xo[2]), 32'd1);
    cmp("rst_rdy0", 0, 32'(rdy[0]), 32'd0);
    rst = 1'b0;
    step();

    // F0 MSB-first, A5 LSB-first, 5-bit zero word with idle level 1.
    clr();
    din0 = 8'hF0; din1 = 8'hA5; din2 = 5'b00000; dv = 3'b111;
    step();
    dv = 3'b000;
    repeat (10) step();
    cmp("f0_stream", 0, cap[0] & 32'hFF, 32'hF0);
    cmp("f0_bits", 0, nc[0], 8);
    cmp("f0_frames", 0, nf[0], 1);
    cmp("a5_lsb_stream", 1, cap[1] & 32'hFF, 32'hA5);
    cmp("a5_bits", 1, nc[1], 8);
    cmp("w5_zero_stream", 2, cap[2] & 32'h1F, 32'h00);
    cmp("w5_bits", 2, nc[2], 5);
    cmp("w5_idle_after", 2, 32'(xo[2]), 32'd1);

    // FF then 0F with valid held: back-to-back, no bubble.
    clr();
    din0 = 8'hFF; dv[0] = 1'b1;
    step();
    din0 = 8'h0F;
    for (int i = 0; i < 20 && !(mact[0] && mword[0][7:0] == 8'h0F); i++) step();
    dv[0] = 1'b0;
    repeat (10) step();
    cmp("b2b_stream", 0, cap[0] & 32'hFFFF, 32'hFF0F);
    cmp("b2b_bits", 0, nc[0], 16);
    cmp("b2b_frames", 0, nf[0], 2);

    // valid pulsed mid-word is ignored.
    clr();
    din0 = 8'h3C; dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    repeat (2) step();
    din0 = 8'hFF; dv[0] = 1'b1;
    step();
    dv[0] = 1'b0; din0 = 8'h00;
    repeat (8) step();
    cmp("mid_stream", 0, cap[0] & 32'hFF, 32'h3C);
    cmp("mid_bits", 0, nc[0], 8);
    cmp("mid_idle_xv", 0, 32'(xv[0]), 32'd0);
    cmp("mid_idle_xo", 0, 32'(xo[0]), 32'd0);

    // Reset during bit 5 of AA, then a fresh word right after reset drops.
    clr();
    din0 = 8'hAA; dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    repeat (4) step();
    cmp("abort_partial", 0, cap[0] & 32'h1F, 32'h15);
    cmp("abort_nbits", 0, nc[0], 5);
    rst = 1'b1;
    step();
    cmp("abort_xv", 0, 32'(xv[0]), 32'd0);
    cmp("abort_xo", 0, 32'(xo[0]), 32'd0);
    cmp("abort_busy", 0, 32'(bz[0]), 32'd0);
    clr();
    rst = 1'b0; din0 = 8'h5A; dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    repeat (10) step();
    cmp("post_rst_stream", 0, cap[0] & 32'hFF, 32'h5A);
    cmp("post_rst_bits", 0, nc[0], 8);
    cmp("post_rst_frames", 0, nf[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
